// File: rtl/param_count_engine.sv
// rtl/param_count_engine.sv - programmable arithmetic sequence generator with valid/ready output (optional: PARAM_COUNT_AUTORELOAD_EN)
module param_count_engine #(
  parameter int W                = 8,
  parameter bit ZERO_STEP_AS_ONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] limit_i,
  input  logic [W-1:0] step_i,
  input  logic         down_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         step_err
`ifdef PARAM_COUNT_AUTORELOAD_EN
  ,
  input  logic         reload_i,
  output logic [15:0]  pass_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CMP  = 3'd2,
    S_OUT  = 3'd3,
    S_STEP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] a_q, base_q, lim_q, stp_q;
  logic         dn_q;
  logic [W:0]   next_val;
  logic         cont, zero_err;
  logic         load_cfg, load_a, upd_a, set_ovf, set_err, reload_go;

  // One extra bit on the step result exposes carry (up) or borrow (down)
  assign next_val = dn_q ? ({1'b0, a_q} - {1'b0, stp_q}) : ({1'b0, a_q} + {1'b0, stp_q});
  assign cont     = dn_q ? (a_q > lim_q) : (a_q < lim_q);
  assign zero_err = (step_i == '0) && !ZERO_STEP_AS_ONE;

  assign out_valid = (state == S_OUT);
  assign out_data  = a_q;
  assign busy      = (state == S_INIT) || (state == S_CMP) || (state == S_OUT) || (state == S_STEP);
  assign done      = (state == S_DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    state_nxt = state;
    load_cfg  = 1'b0;
    load_a    = 1'b0;
    upd_a     = 1'b0;
    set_ovf   = 1'b0;
    set_err   = 1'b0;
    reload_go = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_cfg  = 1'b1;
          set_err   = zero_err;
          state_nxt = zero_err ? S_DONE : S_INIT;
        end
`ifdef PARAM_COUNT_AUTORELOAD_EN
        else if (state == S_DONE && reload_i && !overflow && !step_err) begin
          reload_go = 1'b1;
          state_nxt = S_INIT;
        end
`endif
      end
      S_INIT: begin
        load_a    = 1'b1;
        state_nxt = S_CMP;
      end
      S_CMP:  state_nxt = cont ? S_OUT : S_DONE;
      S_OUT:  if (out_ready) state_nxt = S_STEP;
      S_STEP: begin
        if (next_val[W]) begin
          set_ovf   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          upd_a     = 1'b1;
          state_nxt = S_CMP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration latch, value register and sticky per-run flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      base_q   <= '0;
      lim_q    <= '0;
      stp_q    <= '0;
      dn_q     <= 1'b0;
      overflow <= 1'b0;
      step_err <= 1'b0;
    end else begin
      if (load_cfg) begin
        base_q   <= start_i;
        lim_q    <= limit_i;
        stp_q    <= (step_i == '0 && ZERO_STEP_AS_ONE) ? {{(W-1){1'b0}}, 1'b1} : step_i;
        dn_q     <= down_i;
        overflow <= 1'b0;
        step_err <= set_err;
      end
      if (load_a) a_q <= base_q;
      if (upd_a)  a_q <= next_val[W-1:0];
      if (set_ovf) overflow <= 1'b1;
    end
  end

`ifdef PARAM_COUNT_AUTORELOAD_EN
  // Saturating count of automatic re-runs since the last explicit start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              pass_cnt <= 16'd0;
    else if (load_cfg)                    pass_cnt <= 16'd0;
    else if (reload_go && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
  end
`else
  logic unused_reload;
  assign unused_reload = reload_go;
`endif

endmodule
